// File: rtl/tpu_pkg.sv
// Shared TPU defaults and the result-drain state encoding.
package tpu_pkg;

   localparam int unsigned ADDRESSSIZE_DEF    = 10;
   localparam int unsigned MATRIX_SIZE_DEF    = 64;
   localparam int unsigned PARTIAL_SUM_BW_DEF = 24;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } drain_state_t;

endpackage

// File: rtl/result_drain_ctrl_skid_fifo.sv
// Two-entry FIFO that absorbs the result SRAM read latency ahead of the host port.
module drain_skid_fifo #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(push) - 2'(pop);
      end
   end

   always_comb begin
      head = mem[rd_ptr];
   end

endmodule

// File: rtl/result_drain_ctrl.sv
// Result SRAM drain engine: streams MATRIX_SIZE rows to the host after an end_ rise.
// Optional running checksum output enabled by defining RESULT_DRAIN_CSUM_EN.
module result_drain_ctrl
   import tpu_pkg::*;
#(
   parameter int unsigned ADDRESSSIZE     = ADDRESSSIZE_DEF,
   parameter int unsigned MATRIX_SIZE     = MATRIX_SIZE_DEF,
   parameter int unsigned PARTIAL_SUM_BW  = PARTIAL_SUM_BW_DEF,
   parameter int unsigned WORDSIZE_Result = MATRIX_SIZE * PARTIAL_SUM_BW,
   parameter int unsigned BASE_ADDR       = 0
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       end_,
   output logic                       sram_rd_en,
   output logic [ADDRESSSIZE-1:0]     sram_rd_addr,
   input  logic [WORDSIZE_Result-1:0] sram_rd_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WORDSIZE_Result-1:0] out_data,
   output logic [ADDRESSSIZE-1:0]     out_row,
   output logic                       out_last,
   output logic                       busy,
   output logic                       done,
`ifdef RESULT_DRAIN_CSUM_EN
   output logic [31:0]                csum,
`endif
   output logic                       overrun
);

   localparam int unsigned CNT_W   = $clog2(MATRIX_SIZE + 1);
   localparam int unsigned ENTRY_W = WORDSIZE_Result + ADDRESSSIZE;

   drain_state_t           state;
   logic                   end_q;
   logic                   rise;
   logic                   start;
   logic                   pop;
   logic [CNT_W-1:0]       issue_cnt;
   logic                   rd_en_q;
   logic [ADDRESSSIZE-1:0] rd_row_q;
   logic [1:0]             occ;
   logic [ENTRY_W-1:0]     head;

   drain_skid_fifo #(
      .WIDTH(ENTRY_W)
   ) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .flush    (start),
      .push     (rd_en_q),
      .push_data({sram_rd_data, rd_row_q}),
      .pop      (pop),
      .head     (head),
      .count    (occ)
   );

   // Issue is gated on buffered + on-bus rows net of this cycle's pop, so the
   // read launched now always has a FIFO slot when its data lands.
   always_comb begin
      rise         = end_ && !end_q;
      start        = (state == IDLE) && rise;
      out_valid    = (occ != 2'd0);
      pop          = out_valid && out_ready;
      sram_rd_en   = (state == RUN) && (issue_cnt < CNT_W'(MATRIX_SIZE)) &&
                     ((32'(occ) + 32'(rd_en_q)) < (32'd2 + 32'(pop)));
      sram_rd_addr = ADDRESSSIZE'(BASE_ADDR + 32'(issue_cnt));
      out_data     = head[ENTRY_W-1 -: WORDSIZE_Result];
      out_row      = head[ADDRESSSIZE-1:0];
      out_last     = (out_row == ADDRESSSIZE'(MATRIX_SIZE - 1));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         end_q     <= 1'b0;
         issue_cnt <= '0;
         rd_en_q   <= 1'b0;
         rd_row_q  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         end_q   <= end_;
         rd_en_q <= sram_rd_en;
         done    <= 1'b0;
         if (sram_rd_en) begin
            rd_row_q  <= ADDRESSSIZE'(issue_cnt);
            issue_cnt <= issue_cnt + CNT_W'(1);
         end
         case (state)
            IDLE: begin
               if (rise) begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  issue_cnt <= '0;
                  rd_en_q   <= 1'b0;
               end
            end
            RUN: begin
               if (rise) begin
                  overrun <= 1'b1;
               end
               if (pop && out_last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               if (rise) begin
                  overrun <= 1'b1;
               end
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef RESULT_DRAIN_CSUM_EN
   logic [31:0]               row_sum;
   logic [PARTIAL_SUM_BW-1:0] lane;

   always_comb begin
      row_sum = '0;
      lane    = '0;
      for (int unsigned i = 0; i < MATRIX_SIZE; i++) begin
         lane    = out_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
         row_sum = row_sum + {{(32 - PARTIAL_SUM_BW){lane[PARTIAL_SUM_BW-1]}}, lane};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         csum <= '0;
      end else if (start) begin
         csum <= '0;
      end else if (pop) begin
         csum <= csum + row_sum;
      end
   end
`endif

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Directed bench for result_drain_ctrl with a synchronous result SRAM model.
module tb_result_drain_ctrl;

   localparam int AW   = 10;
   localparam int ROWS = 64;
   localparam int PSB  = 24;
   localparam int W    = ROWS * PSB;

   logic          clk = 1'b0;
   logic          rstn;
   logic          end_;
   logic          sram_rd_en;
   logic [AW-1:0] sram_rd_addr;
   logic [W-1:0]  sram_rd_data = '0;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [AW-1:0] out_row;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          overrun;
`ifdef RESULT_DRAIN_CSUM_EN
   logic [31:0]   csum;
`endif

   int   checks   = 0;
   int   failures = 0;
   logic fill_neg = 1'b0;

   always #5 clk = ~clk;

   result_drain_ctrl #(
      .ADDRESSSIZE    (AW),
      .MATRIX_SIZE    (ROWS),
      .PARTIAL_SUM_BW (PSB),
      .BASE_ADDR      (0)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .end_         (end_),
      .sram_rd_en   (sram_rd_en),
      .sram_rd_addr (sram_rd_addr),
      .sram_rd_data (sram_rd_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_row      (out_row),
      .out_last     (out_last),
      .busy         (busy),
      .done         (done),
`ifdef RESULT_DRAIN_CSUM_EN
      .csum         (csum),
`endif
      .overrun      (overrun)
   );

   function automatic logic [W-1:0] row_word(input int r);
      logic [PSB-1:0] v;
      v = fill_neg ? '1 : PSB'(r + 1);
      return {ROWS{v}};
   endfunction

   // Result SRAM: one-cycle synchronous read.
   always @(posedge clk) begin
      if (sram_rd_en) sram_rd_data <= row_word(int'(sram_rd_addr));
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_rd_en",   64'(sram_rd_en), 0);
      check("rst_addr",    64'(sram_rd_addr), 0);
      check("rst_valid",   64'(out_valid), 0);
      check("rst_data",    64'(out_data === '0), 1);
      check("rst_row",     64'(out_row), 0);
      check("rst_last",    64'(out_last), 0);
      check("rst_busy",    64'(busy), 0);
      check("rst_done",    64'(done), 0);
      check("rst_overrun", 64'(overrun), 0);
   endtask

   // mode 0: ready high, 1: random ready, 2: ready low for cycles 1..20
   task automatic drain(input int mode, input int done_exp, input int reset_at,
                        input int rerise_at, input logic check_csum);
      int   exp_row  = 0;
      int   issued   = 0;
      int   popped   = 0;
      int   done_cyc = -1;
      logic prev_stall = 1'b0;
      logic pop_now;
      end_ = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      end_ = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (cyc > 20);
         endcase
         if (rerise_at > 0 && cyc == rerise_at - 2) end_ = 1'b0;
         if (rerise_at > 0 && cyc == rerise_at)     end_ = 1'b1;
         if (cyc == reset_at) begin
            rstn = 1'b0;
            #1;
            check_reset_outputs();
            @(negedge clk);
            rstn = 1'b1;
            out_ready = 1'b0;
            end_ = 1'b0;
            return;
         end
         #1;
         if (cyc == 1) begin
            check("c1_rd_en", 64'(sram_rd_en), 1);
            check("c1_addr",  64'(sram_rd_addr), 0);
            check("c1_busy",  64'(busy), 1);
         end
         if (mode == 0 && cyc == 2) check("c2_valid", 64'(out_valid), 0);
         if (mode == 0 && cyc == 3) check("c3_valid", 64'(out_valid), 1);
         if (mode == 2 && cyc == 20) begin
            check("stall_issued", 64'(issued), 2);
            check("stall_rd_en",  64'(sram_rd_en), 0);
         end
         if (rerise_at > 0 && cyc == rerise_at - 1) check("overrun_before", 64'(overrun), 0);
         if (rerise_at > 0 && cyc == rerise_at + 1) check("overrun_after",  64'(overrun), 1);
         pop_now = out_valid && out_ready;
         check("outstanding", 64'((issued + int'(sram_rd_en) - popped - int'(pop_now)) <= 2), 1);
         if (prev_stall) check("hold_valid", 64'(out_valid), 1);
         if (out_valid) begin
            check("row",  64'(out_row), 64'(exp_row));
            check("data", 64'(out_data === row_word(exp_row)), 1);
            check("last", 64'(out_last), 64'(exp_row == ROWS - 1));
         end
         if (pop_now) exp_row++;
         prev_stall = out_valid && !out_ready;
         issued += int'(sram_rd_en);
         popped += int'(pop_now);
         if (done) begin
            done_cyc = cyc;
`ifdef RESULT_DRAIN_CSUM_EN
            if (check_csum) check("csum", 64'(csum), 64'h0000_0000_FFFF_F000);
`endif
         end
      end
      @(negedge clk);
      #1;
      check("post_busy", 64'(busy), 0);
      check("post_done", 64'(done), 0);
      if (done_exp > 0) check("done_cycle", 64'(done_cyc), 64'(done_exp));
      else              check("done_seen",  64'(done_cyc > 0), 1);
      check("rows_total",   64'(exp_row), ROWS);
      check("issued_total", 64'(issued), ROWS);
      if (check_csum) check("csum_flag_used", 64'(fill_neg), 1);
   endtask

   initial begin
      int restarts = 0;
      rstn = 1'b0;
      end_ = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk);
      rstn = 1'b1;

      drain(0, 67, 0, 0, 1'b0);
      drain(1, -1, 0, 0, 1'b0);
      drain(2, 85, 0, 0, 1'b0);

      // Re-rise during the drain, then end_ stays high afterwards.
      drain(0, 67, 0, 10, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         if (busy || sram_rd_en) restarts++;
      end
      check("no_restart", 64'(restarts), 0);
      check("overrun_sticky", 64'(overrun), 1);

      drain(0, 0, 30, 0, 1'b0);
      drain(0, 67, 0, 0, 1'b0);

`ifdef RESULT_DRAIN_CSUM_EN
      fill_neg = 1'b1;
      drain(0, 67, 0, 0, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/result_drain_ctrl.md
# result_drain_ctrl

Result-readout engine for the TPU: on the rising edge of the array's `end_` done indication it sequentially reads all MATRIX_SIZE rows from the result SRAM and streams them to the host over a valid/ready interface. It replaces bench-driven `sram_result_address` stepping with a flow-controlled reader. A 2-entry output buffer absorbs the 1-cycle SRAM read latency, so host backpressure never loses or duplicates a row.

## Interface
- ADDRESSSIZE, 10, result SRAM address width
- MATRIX_SIZE, 64, rows per drain; also PEs per row
- PARTIAL_SUM_BW, 24, bits per partial sum
- WORDSIZE_Result, MATRIX_SIZE*PARTIAL_SUM_BW, result row width
- BASE_ADDR, 0, address of row 0
- Reset is `rstn`, asynchronous, active-low. The clock is `clk`.
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- end_  in  1  TPU done level; its rising edge starts a drain
- sram_rd_en  out  1  result SRAM read strobe
- sram_rd_addr  out  ADDRESSSIZE  read address
- sram_rd_data  in  WORDSIZE_Result  read data, valid the cycle after sram_rd_en
- out_valid  out  1  out_data holds a row
- out_ready  in  1  host accepts
- out_data  out  WORDSIZE_Result  result row
- out_row  out  ADDRESSSIZE  row index 0..MATRIX_SIZE-1 of out_data
- out_last  out  1  out_row == MATRIX_SIZE-1
- busy  out  1  drain in progress
- done  out  1  one-cycle pulse after the last row handshake
- overrun  out  1  sticky: an end_ rising edge arrived while busy

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE: when end_ is high at an edge and end_q (registered end_) is low, go to RUN and clear issue_cnt, pop_cnt and the buffer.
- RUN, read issue: sram_rd_en=1 when issue_cnt < MATRIX_SIZE and (occupancy + inflight − pop) < 2.
  - pop = out_valid && out_ready.
  - inflight = the sram_rd_en of the previous cycle.
  - sram_rd_addr = BASE_ADDR + issue_cnt, truncated to ADDRESSSIZE (wraps).
  - issue_cnt increments on each issue.
- RUN, buffer: sram_rd_data is written into the 2-entry FIFO the cycle after issue, tagged with its row index.
  - out_data, out_row and out_last come from the FIFO head.
  - out_valid = occupancy != 0.
  - Push and pop in the same cycle are allowed.
- Once valid is asserted, out_data, out_row and out_last hold stable until the handshake.
- On a handshake with out_last=1, go to DONE. DONE lasts one cycle with done=1, then returns to IDLE.
- busy = (state != IDLE).
- An end_ rising edge while in RUN or DONE is ignored, except that it sets overrun. overrun clears only on reset.
- end_ held high after a drain does not retrigger. A new low→high transition is required.

## Timing
- Reset values: sram_rd_en=0, sram_rd_addr=BASE_ADDR, out_valid=0, out_data=0, out_row=0, out_last=0, busy=0, done=0, overrun=0.
  - The FIFO is emptied, and any inflight read is discarded.
- Reset is legal mid-drain. There is no resume.
- Cycle 0: edge samples end_ rise → RUN.
- Cycle 1: sram_rd_en=1, addr=BASE_ADDR.
- Cycle 2: data is present on sram_rd_data.
- Cycle 3: out_valid=1 with row 0.
- With out_ready held high: one row per cycle, rows 0..63 in cycles 3..66, done=1 in cycle 67, busy=0 from cycle 68.
- With out_ready low: at most 2 reads are outstanding or buffered, and sram_rd_en drops.
- Issue resumes in the same cycle that a pop occurs.

## Configuration
- RESULT_DRAIN_CSUM_EN defined:
  - Adds output `csum` (32 bits): the wrapping sum of all MATRIX_SIZE×MATRIX_SIZE partial sums handed out, each treated as a signed PARTIAL_SUM_BW value sign-extended to 32 bits.
  - The sum accumulates on each handshake and clears on drain start and on reset.
  - csum is valid in the done cycle and holds until the next drain start.
- Not defined: no csum port and no adder logic.

## Structure
- Package `tpu_pkg` holds:
  - Defaults for ADDRESSSIZE, MATRIX_SIZE and PARTIAL_SUM_BW.
  - The `drain_state_t` enum {IDLE, RUN, DONE}.
- One sub-module: `drain_skid_fifo`, a 2-entry FIFO of width WORDSIZE_Result+ADDRESSSIZE with push/pop/occupancy.

## Test plan
- Result SRAM preloaded with row i = 64 copies of 24'(i+1); pulse end_ with out_ready=1 → out_valid at cycle 3, rows 0..63 in order, out_last on row 63, done in cycle 67.
- Random out_ready (50%) → all 64 rows delivered exactly once, in order. sram_rd_en never leaves more than 2 rows outstanding or buffered. Data holds stable while valid && !ready.
- out_ready=0 for 20 cycles after start → exactly 2 reads issued, then sram_rd_en=0. Raising out_ready resumes 1 row/cycle.
- Second end_ rise at cycle 10 of a drain → ignored, overrun=1, drain completes normally. end_ held high afterward → no restart.
- rstn low at cycle 30 → all outputs take reset values. A later end_ rise → full drain starting at row 0.
- RESULT_DRAIN_CSUM_EN defined, all partial sums 24'hFFFFFF (−1) → csum = 32'hFFFFF000 (−4096) in the done cycle.
